image_frame_tx: RTL and testbench

IMAGE_FRAME_TX -- requirements
Module: image_frame_tx

---
 rtl/image_frame_tx.sv | 199 +++++++++++++++++++
 tb/tb_image_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_tx.sv
// Image frame transmitter: frames a ready/valid pixel source into a typed word stream.
// Define IMAGE_FRAME_TX_FRAME_COUNT_EN to tag each FRAME_START with a running frame number.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd5
`endif

module image_frame_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_COLS_WIDTH = 11,
    parameter int NUM_ROWS_WIDTH = 10,
    parameter int BLANK_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_COLS_WIDTH-1:0] num_cols,
    input  logic [NUM_ROWS_WIDTH-1:0] num_rows,
    input  logic [BLANK_WIDTH-1:0]    row_blank,
    input  logic [BLANK_WIDTH-1:0]    frame_blank,
    input  logic                      pix_valid,
    input  logic [DATA_WIDTH-1:0]     pix_data,
    output logic                      pix_ready,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [DATA_WIDTH-1:0]     datao,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_START,
        S_PIXELS,
        S_ROW_END,
        S_ROW_BLANK,
        S_FRAME_END,
        S_FRAME_BLANK
    } state_t;

    localparam logic [NUM_COLS_WIDTH-1:0] COL_ONE   = NUM_COLS_WIDTH'(1);
    localparam logic [NUM_ROWS_WIDTH-1:0] ROW_ONE   = NUM_ROWS_WIDTH'(1);
    localparam logic [BLANK_WIDTH-1:0]    BLANK_ONE = BLANK_WIDTH'(1);

    state_t                    state;
    logic [NUM_COLS_WIDTH-1:0] cols_q;
    logic [NUM_ROWS_WIDTH-1:0] rows_q;
    logic [BLANK_WIDTH-1:0]    row_blank_q;
    logic [BLANK_WIDTH-1:0]    frame_blank_q;
    logic [NUM_COLS_WIDTH-1:0] col_cnt;
    logic [NUM_ROWS_WIDTH-1:0] row_cnt;
    logic [BLANK_WIDTH-1:0]    blank_cnt;
    logic [DATA_WIDTH-1:0]     fs_data;
    logic                      last_col;
    logic                      last_row;
    logic                      start_ok;

    // Counters compare against count-1 so a full-scale count never needs a wider register.
    assign last_col = (col_cnt == cols_q - COL_ONE);
    assign last_row = (row_cnt == rows_q - ROW_ONE);
    assign start_ok = enable && (num_cols != '0) && (num_rows != '0);

`ifdef IMAGE_FRAME_TX_FRAME_COUNT_EN
    localparam logic [DATA_WIDTH-1:0] FRAME_ONE = DATA_WIDTH'(1);
    logic [DATA_WIDTH-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == S_FRAME_END) begin
            frame_cnt <= frame_cnt + FRAME_ONE;
        end
    end

    assign fs_data = frame_cnt;
`else
    assign fs_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            dvo           <= 1'b0;
            dtypeo        <= '0;
            datao         <= '0;
            pix_ready     <= 1'b0;
            busy          <= 1'b0;
            cols_q        <= '0;
            rows_q        <= '0;
            row_blank_q   <= '0;
            frame_blank_q <= '0;
            col_cnt       <= '0;
            row_cnt       <= '0;
            blank_cnt     <= '0;
        end else begin
            dvo <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cols_q        <= num_cols;
                        rows_q        <= num_rows;
                        row_blank_q   <= row_blank;
                        frame_blank_q <= frame_blank;
                        col_cnt       <= '0;
                        row_cnt       <= '0;
                        dvo           <= 1'b1;
                        dtypeo        <= `DTYPE_FRAME_START;
                        datao         <= fs_data;
                        busy          <= 1'b1;
                        state         <= S_ROW_START;
                    end
                end
                S_ROW_START: begin
                    dvo       <= 1'b1;
                    dtypeo    <= `DTYPE_ROW_START;
                    datao     <= '0;
                    col_cnt   <= '0;
                    pix_ready <= 1'b1;
                    state     <= S_PIXELS;
                end
                S_PIXELS: begin
                    if (pix_valid) begin
                        dvo    <= 1'b1;
                        dtypeo <= `DTYPE_PIXEL;
                        datao  <= pix_data;
                        if (last_col) begin
                            col_cnt   <= '0;
                            pix_ready <= 1'b0;
                            state     <= S_ROW_END;
                        end else begin
                            col_cnt <= col_cnt + COL_ONE;
                        end
                    end
                end
                S_ROW_END: begin
                    dvo    <= 1'b1;
                    dtypeo <= `DTYPE_ROW_END;
                    datao  <= '0;
                    if (last_row) begin
                        row_cnt <= '0;
                        state   <= S_FRAME_END;
                    end else begin
                        row_cnt <= row_cnt + ROW_ONE;
                        if (row_blank_q != '0) begin
                            blank_cnt <= row_blank_q;
                            state     <= S_ROW_BLANK;
                        end else begin
                            state <= S_ROW_START;
                        end
                    end
                end
                S_ROW_BLANK: begin
                    blank_cnt <= blank_cnt - BLANK_ONE;
                    if (blank_cnt == BLANK_ONE) begin
                        state <= S_ROW_START;
                    end
                end
                S_FRAME_END: begin
                    dvo    <= 1'b1;
                    dtypeo <= `DTYPE_FRAME_END;
                    datao  <= '0;
                    if (frame_blank_q != '0) begin
                        blank_cnt <= frame_blank_q;
                        state     <= S_FRAME_BLANK;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_FRAME_BLANK: begin
                    blank_cnt <= blank_cnt - BLANK_ONE;
                    if (blank_cnt == BLANK_ONE) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_tx.sv
// Bench for image_frame_tx: a word-list model of each frame is compared with the DUT every cycle.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd5
`endif

module tb_image_frame_tx;
    localparam int DW = 8;
    localparam int CW = 11;
    localparam int RW = 10;
    localparam int BW = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enable = 1'b0;
    logic [CW-1:0]           num_cols = '0;
    logic [RW-1:0]           num_rows = '0;
    logic [BW-1:0]           row_blank = '0;
    logic [BW-1:0]           frame_blank = '0;
    logic                    pix_valid = 1'b0;
    logic [DW-1:0]           pix_data = '0;
    logic                    pix_ready;
    logic                    dvo;
    logic [`DTYPE_WIDTH-1:0] dtypeo;
    logic [DW-1:0]           datao;
    logic                    busy;

    always #5 clk = ~clk;

    image_frame_tx #(
        .DATA_WIDTH(DW), .NUM_COLS_WIDTH(CW), .NUM_ROWS_WIDTH(RW), .BLANK_WIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .num_cols(num_cols), .num_rows(num_rows),
        .row_blank(row_blank), .frame_blank(frame_blank),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy)
    );

    typedef struct packed {
        logic                    dv;
        logic [`DTYPE_WIDTH-1:0] dt;
        logic [DW-1:0]           d;
        logic                    bchk;
    } ent_t;

    ent_t                    exp_q[$];
    bit                      vpat[$];
    bit                      mpat[$];
    logic [DW-1:0]           fs_data[$];
    logic [`DTYPE_WIDTH-1:0] m_dt = '0;
    logic [DW-1:0]           m_d = '0;
    int n_cmp = 0, n_bad = 0;
    int next_pix = 0, m_pix = 0, m_frames = 0;
    int popped = 0, drop_at = -1, rst_at = -1;
    bit scramble = 1'b0;
    int seen_pix = 0, seen_dv = 0, seen_re = 0, row0_gaps = 0;

    function automatic logic [DW-1:0] pval(input int n);
        logic [31:0] t;
        t = 32'h3A + 32'(n) * 32'd29;
        return t[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: a gap keeps the previously emitted type/data on the outputs.
    task automatic push(input bit dv, input logic [`DTYPE_WIDTH-1:0] dt,
                        input logic [DW-1:0] d, input bit bchk);
        ent_t e;
        if (dv) begin
            m_dt = dt;
            m_d  = d;
        end
        e.dv = dv; e.dt = m_dt; e.d = m_d; e.bchk = bchk;
        exp_q.push_back(e);
    endtask

    task automatic model_frame(input int cols, input int rows, input int rb, input int fb);
        logic [DW-1:0] fsd;
        int got;
        bit b;
`ifdef IMAGE_FRAME_TX_FRAME_COUNT_EN
        fsd = DW'(m_frames);
`else
        fsd = '0;
`endif
        push(1'b1, `DTYPE_FRAME_START, fsd, 1'b1);
        for (int r = 0; r < rows; r++) begin
            push(1'b1, `DTYPE_ROW_START, '0, 1'b1);
            got = 0;
            while (got < cols) begin
                b = (mpat.size() > 0) ? mpat.pop_front() : 1'b1;
                if (b) begin
                    push(1'b1, `DTYPE_PIXEL, pval(m_pix), 1'b1);
                    m_pix++;
                    got++;
                end else begin
                    push(1'b0, '0, '0, 1'b1);
                end
            end
            push(1'b1, `DTYPE_ROW_END, '0, 1'b1);
            if (r != rows - 1) repeat (rb) push(1'b0, '0, '0, 1'b1);
        end
        push(1'b1, `DTYPE_FRAME_END, '0, 1'b0);
        m_frames++;
        repeat (fb) push(1'b0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        ent_t e;
        bit b;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            check("stream", 32'({dvo, dtypeo, datao}), 32'({e.dv, e.dt, e.d}));
            if (e.bchk) check("busy", 32'(busy), 32'd1);
            if (dvo) seen_dv++;
            if (dvo && dtypeo == `DTYPE_PIXEL) seen_pix++;
            if (!dvo && seen_re == 0) row0_gaps++;
            if (dvo && dtypeo == `DTYPE_ROW_END) seen_re++;
            if (dvo && dtypeo == `DTYPE_FRAME_START) fs_data.push_back(datao);
            if (popped == drop_at) begin
                enable = 1'b0;
                if (scramble) begin
                    num_cols = 11'd1; num_rows = 10'd5; row_blank = '0; frame_blank = '0;
                end
            end
            if (popped == rst_at) begin
                reset = 1'b1;
                exp_q.delete();
            end
        end
        if (pix_ready) begin
            b = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
            pix_valid = b;
            pix_data  = b ? pval(next_pix) : 8'hEE;
            if (b) next_pix++;
        end else begin
            pix_valid = 1'b1;
            pix_data  = 8'hEE;
        end
    endtask

    task automatic clear_model();
        m_dt = '0; m_d = '0; m_pix = 0; next_pix = 0; m_frames = 0;
        vpat.delete(); mpat.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        check("reset_state", 32'({dvo, busy, pix_ready, dtypeo, datao}), 32'd0);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic start(input int cols, input int rows, input int rb, input int fb,
                         input int frames, input int drop);
        num_cols = CW'(cols); num_rows = RW'(rows);
        row_blank = BW'(rb); frame_blank = BW'(fb);
        popped = 0; drop_at = drop;
        seen_pix = 0; seen_dv = 0; seen_re = 0; row0_gaps = 0;
        fs_data.delete();
        mpat = vpat;
        for (int f = 0; f < frames; f++) model_frame(cols, rows, rb, fb);
        enable = 1'b1;
    endtask

    task automatic run_stream();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 20000) begin
            tick();
            g++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: %0d words left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input string name, input int n);
        repeat (n) begin
            tick();
            check(name, 32'({pix_ready, busy, dvo}), 32'd0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic 4x2 frame, enable pulsed for one sample.
        start(4, 2, 2, 3, 1, 1);
        check("model_len_basic", exp_q.size(), 32'd19);
        run_stream();
        check("words_basic", seen_dv, 32'd14);
        check("pixels_basic", seen_pix, 32'd8);
        idle_check("idle_after_basic", 4);

        // Three-cycle source stall after the second pixel of row 0.
        vpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        start(4, 2, 2, 3, 1, 1);
        check("model_len_stall", exp_q.size(), 32'd22);
        run_stream();
        check("row0_gaps", row0_gaps, 32'd3);
        check("pixels_stall", seen_pix, 32'd8);
        idle_check("idle_after_stall", 3);

        // Enable held high, no frame blanking: back-to-back frames.
        do_reset();
        start(3, 2, 1, 0, 3, 39);
        check("model_len_b2b", exp_q.size(), 32'd39);
        run_stream();
        check("fs_count", fs_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
`ifdef IMAGE_FRAME_TX_FRAME_COUNT_EN
            check("fs_frame_num", (fs_data.size() > i) ? 32'(fs_data[i]) : 32'hDEAD, 32'(i));
`else
            check("fs_frame_num", (fs_data.size() > i) ? 32'(fs_data[i]) : 32'hDEAD, 32'd0);
`endif
        end
        idle_check("idle_after_b2b", 3);

        // Enable dropped after ROW_START, configuration scrambled mid-frame.
        scramble = 1'b1;
        start(4, 2, 2, 3, 1, 2);
        run_stream();
        scramble = 1'b0;
        check("pixels_drop", seen_pix, 32'd8);
        idle_check("idle_after_drop", 5);

        // Reset during row 1 pixels aborts the frame.
        do_reset();
        rst_at = 12;
        start(4, 2, 2, 3, 1, 1);
        run_stream();
        rst_at = -1;
        tick();
        check("rst_abort", 32'({dvo, busy, pix_ready}), 32'd0);
        reset = 1'b0;
        clear_model();
        idle_check("no_fe_after_rst", 4);
        start(4, 2, 2, 3, 1, 1);
        run_stream();
        check("pixels_restart", seen_pix, 32'd8);

        // Zero column or row count never starts a frame.
        num_cols = '0; num_rows = 10'd2; enable = 1'b1;
        idle_check("zero_cols", 8);
        num_cols = 11'd3; num_rows = '0;
        idle_check("zero_rows", 4);
        enable = 1'b0;
        tick();

        // Single-column rows with stalls, no row blanking.
        vpat = '{1'b0, 1'b1, 1'b0, 1'b0};
        start(1, 3, 0, 1, 1, 1);
        run_stream();
        check("pixels_narrow", seen_pix, 32'd3);

        // Full-scale counts.
        start(2047, 2, 0, 0, 1, 1);
        run_stream();
        check("pixels_maxcols", seen_pix, 32'd4094);
        start(1, 1023, 0, 0, 1, 1);
        run_stream();
        check("rows_maxrows", seen_re, 32'd1023);
        idle_check("idle_final", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
